// File: rtl/ftf_decoder_42_if.sv
// Valid/ready bundle between the FTF TSV receive register and the FNS decoder.
// The decoder is the slave; the codeword source and result consumer form the master.
interface ftf_decoder_42_if #(
  parameter int unsigned FbLen = 29
);
  logic [41:0]      code_in;
  logic             in_valid;
  logic             in_ready;
  logic [FbLen-1:0] data_out;
  logic             out_valid;
  logic             out_ready;
  logic             overflow;

  modport master (
    output code_in, in_valid, out_ready,
    input  in_ready, data_out, out_valid, overflow
  );

  modport slave (
    input  code_in, in_valid, out_ready,
    output in_ready, data_out, out_valid, overflow
  );
endinterface

// File: rtl/ftf_decoder_42.sv
// Multi-cycle FNS decoder for the 42-wire FTF TSV link: sums the Fibonacci weights of the set
// codeword bits, BITS_PER_CYCLE bits per cycle, LSB group first.
module ftf_decoder_42 #(
  parameter int unsigned BITS_PER_CYCLE = 7
) (
  input logic             clock,
  input logic             reset,
  ftf_decoder_42_if.slave bus
);
  localparam int unsigned NBits = 42;
  localparam int unsigned Ngrp  = NBits / BITS_PER_CYCLE;
  localparam int unsigned GrpW  = (Ngrp > 1) ? $clog2(Ngrp) : 1;

  // FNS weight k: FNS01 = FNS02 = 1, FNSk = FNS(k-1) + FNS(k-2).
  function automatic logic [63:0] fns(input int unsigned k);
    logic [63:0] a, b, n;
    a = 64'd1;
    b = 64'd1;
    for (int unsigned i = 1; i < k; i++) begin
      n = a + b;
      a = b;
      b = n;
    end
    return a;
  endfunction

  // Data width covers every encodable value 0 .. FNS43-1; one extra accumulator bit flags overflow.
  localparam int unsigned FBLEN42 = $clog2(fns(NBits + 1));
  localparam int unsigned AccW    = FBLEN42 + 1;

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  logic [AccW-1:0] weight [NBits];
  for (genvar k = 0; k < NBits; k++) begin : g_weight
    assign weight[k] = AccW'(fns(k + 1));
  end

  state_e             st_q, st_d;
  logic [NBits-1:0]   code_q, code_d;
  logic [AccW-1:0]    acc_q, acc_d;
  logic [GrpW-1:0]    grp_q, grp_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [FBLEN42-1:0] data_q, data_d;
  logic               ovf_q, ovf_d;
  logic [AccW-1:0]    grp_sum;
  logic [5:0]         idx;

  always_comb begin
    grp_sum = '0;
    idx     = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      idx = 6'(32'(grp_q) * BITS_PER_CYCLE + 32'(j));
      if (code_q[idx]) begin
        grp_sum = grp_sum + weight[idx];
      end
    end
  end

  always_comb begin
    st_d        = st_q;
    code_d      = code_q;
    acc_d       = acc_q;
    grp_d       = grp_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    ovf_d       = ovf_q;
    unique case (st_q)
      StIdle: begin
        if (bus.in_valid) begin
          code_d     = bus.code_in;
          acc_d      = '0;
          grp_d      = '0;
          in_ready_d = 1'b0;
          st_d       = StAccum;
        end
      end
      StAccum: begin
        acc_d = acc_q + grp_sum;
        grp_d = grp_q + GrpW'(1);
        if (grp_q == GrpW'(Ngrp - 1)) begin
          data_d      = acc_d[FBLEN42-1:0];
          ovf_d       = acc_d[FBLEN42];
          out_valid_d = 1'b1;
          st_d        = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          st_d        = StIdle;
        end
      end
      default: begin
        st_d        = StIdle;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q        <= StIdle;
      code_q      <= '0;
      acc_q       <= '0;
      grp_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      st_q        <= st_d;
      code_q      <= code_d;
      acc_q       <= acc_d;
      grp_q       <= grp_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_q;
  assign bus.overflow  = ovf_q;
endmodule
